// File: rtl/avg_pkg.sv
// Shared constants and sample type for the moving-average feed path.
package avg_pkg;
    localparam int AVG_W   = 8;
    localparam int AVG_WIN = 8;

    typedef logic [AVG_W-1:0] avg_sample_t;
endpackage

// File: rtl/avg_feed_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Pushes while full and pops while empty are ignored; pointers wrap naturally.
module avg_feed_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rs,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/avg_feed.sv
// Sample feeder for the 8-tap averager: FIFO-buffered samples issued every DIV clocks.
// Build option AVG_FEED_ZERO_FILL_EN: empty-FIFO ticks issue a zero sample instead of skipping.
module avg_feed
    import avg_pkg::*;
#(
    parameter int WIDTH = AVG_W,
    parameter int DEPTH = 8,
    parameter int DIV   = 2
) (
    input  logic                   clk,
    input  logic                   rs,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       num_in,
    output logic                   num_valid,
    output logic                   win_full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int WCW = $clog2(AVG_WIN) + 1;

    logic [7:0]       presc;
    logic             tick;
    logic [WCW-1:0]   win_cnt;
    logic             full;
    logic             empty;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign in_ready = !full && !rs;
    assign tick     = (presc == 8'(DIV - 1));
    assign pop      = tick && !empty;

    avg_feed_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rs        (rs),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Every issued strobe advances the window counter, which saturates at the window length.
    always_ff @(posedge clk) begin
        if (rs) begin
            presc     <= '0;
            num_in    <= '0;
            num_valid <= 1'b0;
            win_cnt   <= '0;
            win_full  <= 1'b0;
        end else begin
            presc     <= tick ? 8'd0 : presc + 8'd1;
            num_valid <= 1'b0;
            if (tick) begin
                if (!empty) begin
                    num_in    <= head;
                    num_valid <= 1'b1;
                    if (win_cnt != WCW'(AVG_WIN)) begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                    if (win_cnt == WCW'(AVG_WIN - 1)) begin
                        win_full <= 1'b1;
                    end
                end
`ifdef AVG_FEED_ZERO_FILL_EN
                else begin
                    num_in    <= '0;
                    num_valid <= 1'b1;
                    if (win_cnt != WCW'(AVG_WIN)) begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                    if (win_cnt == WCW'(AVG_WIN - 1)) begin
                        win_full <= 1'b1;
                    end
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_avg_feed.sv
// Self-checking bench for avg_feed: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations (DIV = 2).
module tb_avg_feed;
    localparam int DIV   = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rs;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] num_in;
    logic       num_valid;
    logic       win_full;
    logic [3:0] count;

    avg_feed #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rs        (rs),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .num_in    (num_in),
        .num_valid (num_valid),
        .win_full  (win_full),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit r);
        in_valid = v;
        in_data  = d[7:0];
        rs       = r;
        @(posedge clk);
        #2;
    endtask

    // Reference model: a queue, an edge counter since reset, and a window tally.
    int m_q[$];
    int m_k;
    int m_num_in;
    bit m_valid;
    int m_win;
    bit m_live = 1'b0;
    bit m_acc;
    int m_peak;
    int log_val[$];
    int log_k[$];
    int win_k;

    always @(posedge clk) begin
        if (rs) begin
            m_q.delete();
            log_val.delete();
            log_k.delete();
            m_k      = 0;
            m_num_in = 0;
            m_valid  = 1'b0;
            m_win    = 0;
            m_peak   = 0;
            win_k    = -1;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_acc   = in_valid && (m_q.size() < DEPTH);
            m_k++;
            m_valid = 1'b0;
            if (m_k % DIV == 0) begin
                if (m_q.size() > 0) begin
                    m_num_in = m_q.pop_front();
                    m_valid  = 1'b1;
                end
`ifdef AVG_FEED_ZERO_FILL_EN
                else begin
                    m_num_in = 0;
                    m_valid  = 1'b1;
                end
`endif
                if (m_valid) begin
                    log_val.push_back(m_num_in);
                    log_k.push_back(m_k);
                    if (m_win < 8) begin
                        m_win++;
                        if (m_win == 8) win_k = m_k;
                    end
                end
            end
            if (m_acc) m_q.push_back(int'(in_data));
            if (m_q.size() > m_peak) m_peak = m_q.size();
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("count",     int'(count),     m_q.size());
            checkOutput("num_valid", int'(num_valid), int'(m_valid));
            checkOutput("num_in",    int'(num_in),    m_num_in);
            checkOutput("win_full",  int'(win_full),  int'(m_win >= 8));
            checkOutput("in_ready",  int'(in_ready),  int'(!rs && (m_q.size() < DEPTH)));
        end
    end

    int win_vals[8] = '{100, 200, 255, 91, 25, 100, 25, 24};

    initial begin
        int strobes;
        int nonzero;
        int refused;
        int p;

        rs       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #2;
        repeat (2) applyStimulus(0, 0, 1);
        checkOutput("rst_count",     int'(count),     0);
        checkOutput("rst_num_in",    int'(num_in),    0);
        checkOutput("rst_num_valid", int'(num_valid), 0);
        checkOutput("rst_win_full",  int'(win_full),  0);
        checkOutput("rst_in_ready",  int'(in_ready),  0);

        // Two back-to-back samples: issued on ticks at edges 2 and 4.
        applyStimulus(1, 100, 0);
        applyStimulus(1, 200, 0);
        checkOutput("t1_first_valid", int'(num_valid), 1);
        checkOutput("t1_first_data",  int'(num_in),    100);
        applyStimulus(0, 0, 0);
        checkOutput("t1_gap_valid",   int'(num_valid), 0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_second_valid", int'(num_valid), 1);
        checkOutput("t1_second_data",  int'(num_in),    200);
        applyStimulus(0, 0, 0);
        checkOutput("t1_count_drained", int'(count), 0);
        checkOutput("t1_model_k0",  (log_k.size() > 1) ? log_k[0] : -1, 2);
        checkOutput("t1_model_k1",  (log_k.size() > 1) ? log_k[1] : -1, 4);
        checkOutput("t1_model_v1",  (log_val.size() > 1) ? log_val[1] : -1, 200);

        // Eight-sample window: win_full rises with the 8th strobe at edge 16.
        repeat (2) applyStimulus(0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, win_vals[i], 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0);
        checkOutput("win_before_8th", int'(win_full), 0);
        applyStimulus(0, 0, 0);
        checkOutput("win_at_8th",       int'(win_full),  1);
        checkOutput("win_8th_valid",    int'(num_valid), 1);
        checkOutput("win_8th_data",     int'(num_in),    24);
        checkOutput("win_model_edge",   win_k, 16);
        for (int i = 0; i < 8; i++) begin
            checkOutput("win_model_order", (log_val.size() > i) ? log_val[i] : -1, win_vals[i]);
        end

        // Empty FIFO with ticks running.
        strobes = 0;
        nonzero = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0);
            if (num_valid) strobes++;
            if (num_valid && num_in != 0) nonzero++;
        end
        checkOutput("idle_nonzero_strobes", nonzero, 0);
`ifdef AVG_FEED_ZERO_FILL_EN
        checkOutput("idle_strobes", strobes, 5);
        checkOutput("idle_num_in",  int'(num_in), 0);
`else
        checkOutput("idle_strobes", strobes, 0);
        checkOutput("idle_num_in",  int'(num_in), 24);
`endif

        // Reset with five samples queued: they must never be issued.
        for (int i = 0; i < 9; i++) applyStimulus(1, i + 1, 0);
        checkOutput("queued_count", int'(count), 5);
        applyStimulus(0, 0, 1);
        checkOutput("midrst_count",    int'(count),    0);
        checkOutput("midrst_num_in",   int'(num_in),   0);
        checkOutput("midrst_win_full", int'(win_full), 0);
        nonzero = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0);
            if (num_valid && num_in != 0) nonzero++;
        end
        checkOutput("midrst_no_stale", nonzero, 0);

        // Push and tick on the same edge with three queued.
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 11 + i, 0);
        checkOutput("pt_count_before", int'(count), 3);
        applyStimulus(1, 16, 0);
        checkOutput("pt_count_after", int'(count),     3);
        checkOutput("pt_valid",       int'(num_valid), 1);
        checkOutput("pt_data",        int'(num_in),    13);

        // Continuous pushes overrun the 1-per-2-clock drain and fill the FIFO.
        applyStimulus(0, 0, 1);
        refused = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1, $urandom_range(0, 255), 0);
            if (!in_ready) refused++;
        end
        checkOutput("fill_model_peak", m_peak, DEPTH);
        checkOutput("fill_refused_seen", int'(refused > 0), 1);

        // Randomized traffic with bursty load and occasional resets.
        p = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) p = $urandom_range(0, 100);
            applyStimulus($urandom_range(0, 99) < p, $urandom_range(0, 255),
                          $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
